// File: rtl/trigger_delay_pkg.sv
// Shared opcodes, edge encoding, parser states and response lengths for the
// trigger-delay command path.
package trigger_delay_pkg;

    localparam logic [7:0] CMD_SET_DELAY   = 8'h01;
    localparam logic [7:0] CMD_GET_DELAY   = 8'h02;
    localparam logic [7:0] CMD_SET_EDGE    = 8'h03;
    localparam logic [7:0] CMD_GET_EDGE    = 8'h04;
    localparam logic [7:0] CMD_GET_STATUS  = 8'h05;
    localparam logic [7:0] CMD_RESET_COUNT = 8'h06;

    typedef enum logic [1:0] {
        EDGE_NONE    = 2'd0,
        EDGE_RISING  = 2'd1,
        EDGE_FALLING = 2'd2,
        EDGE_BOTH    = 2'd3
    } edge_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARG     = 2'd1,
        ST_RESP    = 2'd2,
        ST_TX_WAIT = 2'd3
    } parser_state_t;

    localparam logic [2:0] RESP_LEN_EDGE   = 3'd1;
    localparam logic [2:0] RESP_LEN_DELAY  = 3'd4;
    localparam logic [2:0] RESP_LEN_STATUS = 3'd6;

endpackage

// File: rtl/trigger_cmd_parser_if.sv
// Byte bus between the UART (master side) and the command parser (slave side).
interface trigger_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_en;

    modport master (output rx_data, rx_data_valid, tx_ready, input tx_data, tx_en);
    modport slave  (input rx_data, rx_data_valid, tx_ready, output tx_data, tx_en);
endinterface

// File: rtl/trigger_resp_serializer.sv
// Holds a snapshotted response of up to 6 bytes and hands it to the UART
// transmitter one byte per tx_ready handshake, LSB first.
module trigger_resp_serializer
    import trigger_delay_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [2:0]  len_i,
    input  logic [47:0] data_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_en_o,
    output logic        done_o
);

    parser_state_t state_q, state_d;
    logic [47:0]   buf_q, buf_d;
    logic [2:0]    remain_q, remain_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_en_q, tx_en_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            // NOTE: the buffer is reset too; it is tiny and keeps tx_data deterministic after reset.
            buf_q     <= '0;
            remain_q  <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of its peers.
            state_q   <= state_d;
            buf_q     <= buf_d;
            remain_q  <= remain_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_d   = state_q;
        buf_d     = buf_q;
        remain_d  = remain_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    buf_d    = data_i;
                    remain_d = len_i;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_ready_i) begin
                    tx_data_d = buf_q[7:0];
                    buf_d     = {8'h00, buf_q[47:8]};
                    remain_d  = remain_q - 3'd1;
                    tx_en_d   = 1'b1;
                    state_d   = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // The strobe cycle itself is the mandatory one-cycle wait.
                if (!tx_en_q && tx_ready_i) begin
                    if (remain_q == 3'd0) begin
                        done_o  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_data_o = tx_data_q;
    assign tx_en_o   = tx_en_q;

endmodule

// File: rtl/trigger_cmd_parser.sv
// Host command decoder for the trigger-delay core: opcode/argument FSM,
// configuration registers and response launch. Optional macro: CMD_TIMEOUT_EN.
module trigger_cmd_parser
    import trigger_delay_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DELAY  = 32'd0,
    parameter logic [1:0]  DEFAULT_EDGE   = 2'b01,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trigger_cmd_parser_if.slave  bus,
    input  logic [15:0]          trigger_count,
    output logic [31:0]          delay_cycles,
    output logic [1:0]           edge_sel,
    output logic                 count_clear,
    output logic                 cfg_update,
    output logic                 cmd_err
);

    parser_state_t state_q, state_d;
    logic          arg_is_edge_q, arg_is_edge_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   delay_q, delay_d;
    edge_t         edge_q, edge_d;
    logic          count_clear_q, count_clear_d;
    logic          cfg_update_q, cfg_update_d;
    logic          cmd_err_q, cmd_err_d;

    logic          ser_load;
    logic [2:0]    ser_len;
    logic [47:0]   ser_data;
    logic          ser_done;
    logic          timeout;
    logic [7:0]    tx_data;
    logic          tx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            arg_is_edge_q <= 1'b0;
            shadow_q      <= '0;
            idx_q         <= '0;
            delay_q       <= DEFAULT_DELAY;
            edge_q        <= edge_t'(DEFAULT_EDGE);
            count_clear_q <= 1'b0;
            cfg_update_q  <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            arg_is_edge_q <= arg_is_edge_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            delay_q       <= delay_d;
            edge_q        <= edge_d;
            count_clear_q <= count_clear_d;
            cfg_update_q  <= cfg_update_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [31:0] timer_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q == ST_ARG && !bus.rx_data_valid) begin
            timer_q <= timer_q + 32'd1;
        end else begin
            timer_q <= '0;
        end
    end

    assign timeout = (state_q == ST_ARG) && (timer_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        arg_is_edge_d = arg_is_edge_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        delay_d       = delay_q;
        edge_d        = edge_q;
        count_clear_d = 1'b0;
        cfg_update_d  = 1'b0;
        cmd_err_d     = 1'b0;
        ser_load      = 1'b0;
        ser_len       = RESP_LEN_EDGE;
        ser_data      = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_data_valid) begin
                    case (bus.rx_data)
                        CMD_SET_DELAY, CMD_SET_EDGE: begin
                            arg_is_edge_d = (bus.rx_data == CMD_SET_EDGE);
                            shadow_d      = '0;
                            idx_d         = '0;
                            state_d       = ST_ARG;
                        end
                        CMD_GET_DELAY: begin
                            ser_load = 1'b1;
                            ser_len  = RESP_LEN_DELAY;
                            ser_data = {16'h0000, delay_q};
                            state_d  = ST_RESP;
                        end
                        CMD_GET_EDGE: begin
                            ser_load = 1'b1;
                            ser_len  = RESP_LEN_EDGE;
                            ser_data = {46'd0, edge_q};
                            state_d  = ST_RESP;
                        end
                        CMD_GET_STATUS: begin
                            ser_load = 1'b1;
                            ser_len  = RESP_LEN_STATUS;
                            ser_data = {delay_q, trigger_count};
                            state_d  = ST_RESP;
                        end
                        CMD_RESET_COUNT: count_clear_d = 1'b1;
                        default:         cmd_err_d     = 1'b1;
                    endcase
                end
            end
            ST_ARG: begin
                if (bus.rx_data_valid) begin
                    // Little-endian: each byte enters at the top and the word shifts down.
                    shadow_d = {bus.rx_data, shadow_q[31:8]};
                    idx_d    = idx_q + 2'd1;
                    if (arg_is_edge_q) begin
                        state_d = ST_IDLE;
                        if (bus.rx_data[7:2] == 6'd0) begin
                            edge_d       = edge_t'(bus.rx_data[1:0]);
                            cfg_update_d = 1'b1;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else if (idx_q == 2'd3) begin
                        delay_d      = {bus.rx_data, shadow_q[31:8]};
                        cfg_update_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else if (timeout) begin
                    shadow_d  = '0;
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus.rx_data_valid) cmd_err_d = 1'b1;
                if (ser_done)          state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    trigger_resp_serializer u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ser_load),
        .len_i      (ser_len),
        .data_i     (ser_data),
        .tx_ready_i (bus.tx_ready),
        .tx_data_o  (tx_data),
        .tx_en_o    (tx_en),
        .done_o     (ser_done)
    );

    assign bus.tx_data   = tx_data;
    assign bus.tx_en     = tx_en;
    assign delay_cycles  = delay_q;
    assign edge_sel      = edge_q;
    assign count_clear   = count_clear_q;
    assign cfg_update    = cfg_update_q;
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_trigger_cmd_parser.sv
// Directed bench for trigger_cmd_parser; response bytes are checked against a
// scoreboard queue filled when each GET command is sent.
module tb_trigger_cmd_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] trigger_count = '0;
    logic [31:0] delay_cycles;
    logic [1:0]  edge_sel;
    logic        count_clear;
    logic        cfg_update;
    logic        cmd_err;

    trigger_cmd_parser_if bus ();

    trigger_cmd_parser #(.TIMEOUT_CYCLES(50)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .trigger_count (trigger_count),
        .delay_cycles  (delay_cycles),
        .edge_sel      (edge_sel),
        .count_clear   (count_clear),
        .cfg_update    (cfg_update),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cfg    = 0;
    int n_err    = 0;
    int n_clr    = 0;
    int n_tx     = 0;
    int cycle    = 0;
    int last_tx_cycle = -100;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            n_cfg += int'(cfg_update);
            n_err += int'(cmd_err);
            n_clr += int'(count_clear);
            if (bus.tx_en) begin
                n_tx++;
                check("tx_gap_ge2", 32'(cycle - last_tx_cycle >= 2), 32'd1);
                last_tx_cycle = cycle;
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 32'(bus.tx_en), 32'd0);
                end else begin
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int cfg0, err0, clr0, tx0;
        bus.rx_data       = '0;
        bus.rx_data_valid = 1'b0;
        bus.tx_ready      = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_count_clear", 32'(count_clear), 32'd0);
        check("rst_cfg_update", 32'(cfg_update), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_delay", delay_cycles, 32'd0);
        check("rst_edge", 32'(edge_sel), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SET_DELAY 1000: no partial value, exactly one cfg_update.
        cfg0 = n_cfg;
        send_byte(8'h01); send_byte(8'hE8); send_byte(8'h03); send_byte(8'h00);
        check("set_delay_partial", delay_cycles, 32'd0);
        send_byte(8'h00);
        check("set_delay_value", delay_cycles, 32'd1000);
        check("set_delay_cfg_pulse", 32'(cfg_update), 32'd1);
        repeat (3) @(negedge clk);
        check("set_delay_cfg_count", 32'(n_cfg - cfg0), 32'd1);

        // GET_DELAY with first tx_en exactly two cycles after the opcode strobe.
        exp_q.push_back(8'hE8); exp_q.push_back(8'h03);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_byte(8'h02);
        check("get_delay_lat_n1", 32'(bus.tx_en), 32'd0);
        @(negedge clk);
        check("get_delay_lat_n2", 32'(bus.tx_en), 32'd1);
        drain("get_delay_drain");

        // SET_EDGE FALLING, then GET_EDGE held off by tx_ready.
        send_byte(8'h03); send_byte(8'h02);
        check("set_edge_value", 32'(edge_sel), 32'd2);
        bus.tx_ready = 1'b0;
        tx0 = n_tx;
        exp_q.push_back(8'h02);
        send_byte(8'h04);
        repeat (6) @(negedge clk);
        check("get_edge_gated", 32'(n_tx - tx0), 32'd0);
        bus.tx_ready = 1'b1;
        drain("get_edge_drain");

        // SET_EDGE with an illegal value.
        cfg0 = n_cfg; err0 = n_err;
        send_byte(8'h03); send_byte(8'h07);
        check("set_edge_bad_err", 32'(cmd_err), 32'd1);
        check("set_edge_bad_keep", 32'(edge_sel), 32'd2);
        @(negedge clk);
        check("set_edge_bad_nocfg", 32'(n_cfg - cfg0), 32'd0);
        check("set_edge_bad_errcnt", 32'(n_err - err0), 32'd1);

        // GET_STATUS snapshot must survive a trigger_count change mid-response.
        send_byte(8'h01); send_byte(8'hC8); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("set_delay_200", delay_cycles, 32'd200);
        trigger_count = 16'd5;
        exp_q.push_back(8'h05); exp_q.push_back(8'h00); exp_q.push_back(8'hC8);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_byte(8'h05);
        repeat (4) @(negedge clk);
        trigger_count = 16'hABCD;
        drain("get_status_drain");

        // RESET_COUNT: one pulse.
        clr0 = n_clr;
        send_byte(8'h06);
        check("reset_count_pulse", 32'(count_clear), 32'd1);
        repeat (3) @(negedge clk);
        check("reset_count_once", 32'(n_clr - clr0), 32'd1);

        // Invalid opcode.
        cfg0 = n_cfg;
        send_byte(8'hFF);
        check("bad_op_err", 32'(cmd_err), 32'd1);
        check("bad_op_delay", delay_cycles, 32'd200);
        check("bad_op_edge", 32'(edge_sel), 32'd2);
        check("bad_op_nocfg", 32'(n_cfg - cfg0), 32'd0);
        exp_q.push_back(8'hC8); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_byte(8'h02);
        drain("bad_op_get_delay");

        // A byte arriving during a response is dropped.
        err0 = n_err;
        exp_q.push_back(8'h02);
        send_byte(8'h04);
        send_byte(8'h01);
        check("drop_err", 32'(cmd_err), 32'd1);
        drain("drop_drain");
        check("drop_errcnt", 32'(n_err - err0), 32'd1);
        exp_q.push_back(8'h02);
        send_byte(8'h04);
        drain("drop_then_idle");

        // Reset in the middle of SET_DELAY arguments.
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_delay", delay_cycles, 32'd0);
        check("midrst_edge", 32'(edge_sel), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h01); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("after_rst_delay", delay_cycles, 32'h1234_5678);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        send_byte(8'h02);
        drain("after_rst_get");

`ifdef CMD_TIMEOUT_EN
        // Argument timeout leaves configuration untouched.
        err0 = n_err; cfg0 = n_cfg;
        send_byte(8'h01); send_byte(8'h10);
        repeat (60) @(negedge clk);
        check("timeout_err", 32'(n_err - err0), 32'd1);
        check("timeout_nocfg", 32'(n_cfg - cfg0), 32'd0);
        check("timeout_delay", delay_cycles, 32'h1234_5678);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        send_byte(8'h02);
        drain("timeout_get_delay");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
